// File: rtl/mem_port_arbiter_if.sv
// CPU-side and memory-side handshake bundle for mem_port_arbiter.
// slave is the arbiter's view; master is the CPU/memory environment's view.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              ins_req_i;
  logic [ADDR_W-1:0] ins_addr_i;
  logic [DATA_W-1:0] ins_rdata_o;
  logic              ins_valid_o;

  logic              data_read_i;
  logic              data_write_i;
  logic [ADDR_W-1:0] data_addr_i;
  logic [DATA_W-1:0] data_wdata_i;
  logic [DATA_W-1:0] data_rdata_o;
  logic              data_valid_o;

  logic              stall_o;

  logic              mem_req_o;
  logic              mem_we_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [DATA_W-1:0] mem_wdata_o;
  logic [DATA_W-1:0] mem_rdata_i;
  logic              mem_ack_i;

  modport slave (
    input  ins_req_i, ins_addr_i,
    output ins_rdata_o, ins_valid_o,
    input  data_read_i, data_write_i, data_addr_i, data_wdata_i,
    output data_rdata_o, data_valid_o,
    output stall_o,
    output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
    input  mem_rdata_i, mem_ack_i
  );

  modport master (
    output ins_req_i, ins_addr_i,
    input  ins_rdata_o, ins_valid_o,
    output data_read_i, data_write_i, data_addr_i, data_wdata_i,
    input  data_rdata_o, data_valid_o,
    input  stall_o,
    input  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
    output mem_rdata_i, mem_ack_i
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one variable-latency memory port between instruction fetch and data access.
// Data wins collisions until MAX_DATA_STREAK consecutive data grants starve a pending fetch.
module mem_port_arbiter #(
  parameter int ADDR_W          = 32,
  parameter int DATA_W          = 32,
  parameter int MAX_DATA_STREAK = 4
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  mem_port_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ISSUE, DONE} state_t;
  typedef enum logic {OWN_INS, OWN_DATA} owner_t;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } mem_cmd_t;

  localparam logic [3:0] STREAK_MAX = 4'(MAX_DATA_STREAK);

  state_t            state;
  owner_t            owner;
  logic [3:0]        streak;
  mem_cmd_t          cmd;
  mem_cmd_t          grant_cmd;
  logic              mem_req;
  logic [DATA_W-1:0] ins_rdata;
  logic [DATA_W-1:0] data_rdata;
  logic              ins_valid;
  logic              data_valid;
  logic              data_req;
  logic              grant_ins;
  logic              grant_data;

  always_comb begin
    data_req        = bus.data_read_i | bus.data_write_i;
    grant_ins       = bus.ins_req_i & (~data_req | (streak == STREAK_MAX));
    grant_data      = data_req & ~grant_ins;
    // a simultaneous read+write is treated as a write
    grant_cmd.we    = grant_data & bus.data_write_i;
    grant_cmd.addr  = grant_ins ? bus.ins_addr_i : bus.data_addr_i;
    grant_cmd.wdata = bus.data_wdata_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state      <= IDLE;
      owner      <= OWN_INS;
      streak     <= '0;
      cmd        <= '0;
      mem_req    <= 1'b0;
      ins_rdata  <= '0;
      data_rdata <= '0;
      ins_valid  <= 1'b0;
      data_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_ins || grant_data) begin
            owner   <= grant_ins ? OWN_INS : OWN_DATA;
            cmd     <= grant_cmd;
            mem_req <= 1'b1;
            state   <= ISSUE;
            // streak only grows while a fetch is actually being held off
            if (grant_ins || !bus.ins_req_i)
              streak <= '0;
            else if (streak != STREAK_MAX)
              streak <= streak + 4'd1;
          end
        end
        ISSUE: begin
          if (bus.mem_ack_i) begin
            mem_req <= 1'b0;
            cmd.we  <= 1'b0;
            state   <= DONE;
            if (owner == OWN_INS) begin
              ins_rdata <= bus.mem_rdata_i;
              ins_valid <= 1'b1;
            end else begin
              if (!cmd.we) data_rdata <= bus.mem_rdata_i;
              data_valid <= 1'b1;
            end
          end
        end
        DONE: begin
          ins_valid  <= 1'b0;
          data_valid <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.mem_req_o    = mem_req;
  assign bus.mem_we_o     = cmd.we;
  assign bus.mem_addr_o   = cmd.addr;
  assign bus.mem_wdata_o  = cmd.wdata;
  assign bus.ins_rdata_o  = ins_rdata;
  assign bus.ins_valid_o  = ins_valid;
  assign bus.data_rdata_o = data_rdata;
  assign bus.data_valid_o = data_valid;
  assign bus.stall_o      = (bus.ins_req_i & ~ins_valid) | (data_req & ~data_valid);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed table, corner sequences,
// and random traffic against a transaction-level reference model.
module tb_mem_port_arbiter;
  localparam int AW   = 16;
  localparam int DW   = 32;
  localparam int MAXS = 4;

  logic clk_i  = 1'b0;
  logic rst_ni = 1'b1;

  mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus();

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_DATA_STREAK(MAXS)) dut (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .bus   (bus)
  );

  always #5 clk_i = ~clk_i;

  int checks   = 0;
  int failures = 0;

  logic [DW-1:0] mem_arr [256];
  bit            mem_auto = 1'b1;
  bit            spur_en  = 1'b0;
  int            mem_lat  = 0;
  int            lat_cnt  = 0;
  logic          ack_at_edge;
  logic [DW-1:0] rdata_at_edge;

  typedef struct {
    logic          ins, rd, wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    int            lat;
    logic          exp_we;
    int            exp_req_cyc;
    logic          exp_ins_own;
    logic [DW-1:0] exp_rdata;
  } vec_t;

  typedef struct {
    logic ins, rd, wr, stall;
  } st_t;

  vec_t vt [5];
  st_t  stv[6];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0h required=%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // One clock: sample ack as seen by the edge, then run the memory model.
  task automatic step();
    @(posedge clk_i);
    ack_at_edge   = bus.mem_ack_i;
    rdata_at_edge = bus.mem_rdata_i;
    #1;
    if (mem_auto) begin
      if (bus.mem_ack_i) bus.mem_ack_i = 1'b0;
      else if (bus.mem_req_o) begin
        if (lat_cnt >= mem_lat) begin
          bus.mem_ack_i = 1'b1;
          lat_cnt = 0;
          if (bus.mem_we_o) begin
            mem_arr[bus.mem_addr_o[7:0]] = bus.mem_wdata_o;
            bus.mem_rdata_i = $urandom;
          end else bus.mem_rdata_i = mem_arr[bus.mem_addr_o[7:0]];
          if (spur_en) mem_lat = $urandom_range(0, 3);
        end else lat_cnt++;
      end else if (spur_en && $urandom_range(0, 15) == 0) begin
        bus.mem_ack_i   = 1'b1;
        bus.mem_rdata_i = $urandom;
      end
    end
    #1;
  endtask

  task automatic drive_idle();
    bus.ins_req_i    = 1'b0;
    bus.data_read_i  = 1'b0;
    bus.data_write_i = 1'b0;
  endtask

  task automatic do_reset();
    drive_idle();
    rst_ni = 1'b0;
    step();
    step();
    rst_ni  = 1'b1;
    lat_cnt = 0;
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, " mem_req"},    bus.mem_req_o,    0);
    chk({nm, " mem_we"},     bus.mem_we_o,     0);
    chk({nm, " mem_addr"},   bus.mem_addr_o,   0);
    chk({nm, " mem_wdata"},  bus.mem_wdata_o,  0);
    chk({nm, " ins_valid"},  bus.ins_valid_o,  0);
    chk({nm, " data_valid"}, bus.data_valid_o, 0);
    chk({nm, " ins_rdata"},  bus.ins_rdata_o,  0);
    chk({nm, " data_rdata"}, bus.data_rdata_o, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] drd_before, ird_before;
    int            req_cyc;
    bit            got, prev_req;
    bit            own_log[$];
    // reference model state
    int            m_phase, m_streak;
    bit            m_own_ins, m_we, e_iv, e_dv, p_ins, p_dreq;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata, m_ird, m_drd;
    int            r;

    for (int i = 0; i < 256; i++) mem_arr[i] = $urandom;
    mem_arr[8'h10] = 32'hDEADBEEF;
    mem_arr[8'h44] = 32'h12345678;
    mem_arr[8'h50] = 32'hCAFEF00D;

    vt[0] = '{1'b1, 1'b0, 1'b0, 16'h0010, 32'h0,    1, 1'b0, 2, 1'b1, 32'hDEADBEEF};
    vt[1] = '{1'b0, 1'b0, 1'b1, 16'h0020, 32'h55,   3, 1'b1, 4, 1'b0, 32'h0};
    vt[2] = '{1'b0, 1'b1, 1'b0, 16'h0044, 32'h0,    0, 1'b0, 1, 1'b0, 32'h12345678};
    vt[3] = '{1'b0, 1'b1, 1'b1, 16'h0060, 32'hA5A5, 2, 1'b1, 3, 1'b0, 32'h0};
    vt[4] = '{1'b1, 1'b0, 1'b0, 16'h0050, 32'h0,    4, 1'b0, 5, 1'b1, 32'hCAFEF00D};

    stv[0] = '{1'b0, 1'b0, 1'b0, 1'b0};
    stv[1] = '{1'b1, 1'b0, 1'b0, 1'b1};
    stv[2] = '{1'b0, 1'b1, 1'b0, 1'b1};
    stv[3] = '{1'b0, 1'b0, 1'b1, 1'b1};
    stv[4] = '{1'b1, 1'b1, 1'b1, 1'b1};
    stv[5] = '{1'b0, 1'b1, 1'b1, 1'b1};

    drive_idle();
    bus.ins_addr_i   = '0;
    bus.data_addr_i  = '0;
    bus.data_wdata_i = '0;
    bus.mem_ack_i    = 1'b0;
    bus.mem_rdata_i  = '0;

    // asynchronous reset at power-up
    #1 rst_ni = 1'b0;
    #1 chk_all_zero("reset");
    step();
    step();
    rst_ni = 1'b1;

    // stall while idle
    foreach (stv[i]) begin
      bus.ins_req_i    = stv[i].ins;
      bus.data_read_i  = stv[i].rd;
      bus.data_write_i = stv[i].wr;
      #1 chk($sformatf("stall_idle[%0d]", i), bus.stall_o, stv[i].stall);
    end
    drive_idle();

    // directed single accesses
    foreach (vt[i]) begin
      bus.ins_req_i    = vt[i].ins;
      bus.data_read_i  = vt[i].rd;
      bus.data_write_i = vt[i].wr;
      bus.ins_addr_i   = vt[i].addr;
      bus.data_addr_i  = vt[i].addr;
      bus.data_wdata_i = vt[i].wdata;
      mem_lat = vt[i].lat;
      lat_cnt = 0;
      drd_before = bus.data_rdata_o;
      ird_before = bus.ins_rdata_o;
      req_cyc = 0;
      got = 0;
      for (int c = 0; c < 40 && !got; c++) begin
        step();
        if (bus.mem_req_o) begin
          req_cyc++;
          chk($sformatf("vec%0d we", i), bus.mem_we_o, vt[i].exp_we);
          chk($sformatf("vec%0d addr", i), bus.mem_addr_o, vt[i].addr);
          if (vt[i].exp_we) chk($sformatf("vec%0d wdata", i), bus.mem_wdata_o, vt[i].wdata);
        end
        if (bus.ins_valid_o || bus.data_valid_o) got = 1;
      end
      chk($sformatf("vec%0d completed", i), got, 1);
      chk($sformatf("vec%0d req_cycles", i), req_cyc, vt[i].exp_req_cyc);
      chk($sformatf("vec%0d ins_valid", i), bus.ins_valid_o, vt[i].exp_ins_own);
      chk($sformatf("vec%0d data_valid", i), bus.data_valid_o, !vt[i].exp_ins_own);
      if (vt[i].exp_ins_own) begin
        chk($sformatf("vec%0d ins_rdata", i), bus.ins_rdata_o, vt[i].exp_rdata);
        chk($sformatf("vec%0d data_rdata kept", i), bus.data_rdata_o, drd_before);
      end else begin
        if (vt[i].exp_we) chk($sformatf("vec%0d data_rdata kept", i), bus.data_rdata_o, drd_before);
        else chk($sformatf("vec%0d data_rdata", i), bus.data_rdata_o, vt[i].exp_rdata);
        chk($sformatf("vec%0d ins_rdata kept", i), bus.ins_rdata_o, ird_before);
      end
      drive_idle();
      step();
      chk($sformatf("vec%0d valid one-shot", i), bus.ins_valid_o | bus.data_valid_o, 0);
      step();
    end
    chk("write landed 0x20", mem_arr[8'h20], 32'h55);
    chk("write landed 0x60", mem_arr[8'h60], 32'hA5A5);

    // collision: data first, fetch in the following IDLE
    do_reset();
    mem_lat = 0;
    bus.ins_req_i   = 1'b1;
    bus.ins_addr_i  = 16'h0030;
    bus.data_read_i = 1'b1;
    bus.data_addr_i = 16'h0040;
    #1 chk("coll stall c0", bus.stall_o, 1);
    for (int k = 1; k <= 7; k++) begin
      step();
      chk($sformatf("coll data_valid c%0d", k), bus.data_valid_o, k == 2);
      chk($sformatf("coll ins_valid c%0d", k), bus.ins_valid_o, k == 5);
      chk($sformatf("coll stall c%0d", k), bus.stall_o, k < 5);
      if (k == 1) chk("coll first addr", bus.mem_addr_o, 16'h0040);
      if (k == 4) chk("coll second addr", bus.mem_addr_o, 16'h0030);
      if (k == 2) bus.data_read_i = 1'b0;
      if (k == 5) bus.ins_req_i = 1'b0;
    end

    // starvation guard: D,D,D,D,I repeating
    do_reset();
    mem_lat = 0;
    bus.ins_req_i   = 1'b1;
    bus.ins_addr_i  = 16'h0100;
    bus.data_read_i = 1'b1;
    bus.data_addr_i = 16'h0200;
    prev_req = 0;
    for (int c = 0; c < 200 && own_log.size() < 20; c++) begin
      step();
      if (bus.mem_req_o && !prev_req) own_log.push_back(bus.mem_addr_o == 16'h0100);
      prev_req = bus.mem_req_o;
    end
    chk("starve grant count", own_log.size(), 20);
    foreach (own_log[j])
      chk($sformatf("starve grant%0d is_ins", j), own_log[j], (j % 5) == 4);
    drive_idle();
    step();
    step();

    // asynchronous reset while an access is outstanding
    mem_auto = 1'b0;
    bus.ins_req_i  = 1'b1;
    bus.ins_addr_i = 16'h0070;
    step();
    chk("rst_mid req up", bus.mem_req_o, 1);
    step();
    bus.ins_req_i = 1'b0;
    rst_ni = 1'b0;
    #1 chk_all_zero("rst_mid");
    step();
    step();
    rst_ni = 1'b1;
    bus.mem_ack_i   = 1'b1;
    bus.mem_rdata_i = 32'h0BAD0BAD;
    step();
    bus.mem_ack_i = 1'b0;
    chk("late ack ins_valid", bus.ins_valid_o, 0);
    chk("late ack data_valid", bus.data_valid_o, 0);
    chk("late ack ins_rdata", bus.ins_rdata_o, 0);
    chk("late ack mem_req", bus.mem_req_o, 0);
    bus.ins_req_i  = 1'b1;
    bus.ins_addr_i = 16'h0010;
    step();
    chk("post-reset grant", bus.mem_req_o, 1);
    chk("post-reset addr", bus.mem_addr_o, 16'h0010);
    mem_auto = 1'b1;
    lat_cnt  = 0;
    mem_lat  = 0;
    got = 0;
    for (int c = 0; c < 20 && !got; c++) begin
      step();
      got = bus.ins_valid_o;
    end
    chk("post-reset fetch done", got, 1);
    chk("post-reset fetch data", bus.ins_rdata_o, 32'hDEADBEEF);
    drive_idle();
    step();

    // random traffic against the transaction-level model
    do_reset();
    spur_en  = 1'b1;
    m_phase  = 0;
    m_streak = 0;
    m_ird    = '0;
    m_drd    = '0;
    m_own_ins = 0;
    m_we     = 0;
    m_addr   = '0;
    m_wdata  = '0;
    for (int c = 0; c < 4000; c++) begin
      step();
      p_ins  = bus.ins_req_i;
      p_dreq = bus.data_read_i | bus.data_write_i;
      e_iv = 0;
      e_dv = 0;
      case (m_phase)
        0: begin
          if (p_ins || p_dreq) begin
            m_own_ins = p_ins && (!p_dreq || m_streak == MAXS);
            if (m_own_ins || !p_ins) m_streak = 0;
            else m_streak = (m_streak < MAXS) ? m_streak + 1 : MAXS;
            m_we    = !m_own_ins && bus.data_write_i;
            m_addr  = m_own_ins ? bus.ins_addr_i : bus.data_addr_i;
            m_wdata = bus.data_wdata_i;
            chk("rnd grant req", bus.mem_req_o, 1);
            chk("rnd grant addr", bus.mem_addr_o, m_addr);
            chk("rnd grant we", bus.mem_we_o, m_we);
            if (m_we) chk("rnd grant wdata", bus.mem_wdata_o, m_wdata);
            m_phase = 1;
          end else chk("rnd idle req", bus.mem_req_o, 0);
        end
        1: begin
          if (ack_at_edge) begin
            if (m_own_ins) m_ird = rdata_at_edge;
            else if (!m_we) m_drd = rdata_at_edge;
            e_iv = m_own_ins;
            e_dv = !m_own_ins;
            chk("rnd done req", bus.mem_req_o, 0);
            m_phase = 2;
          end else begin
            chk("rnd hold req", bus.mem_req_o, 1);
            chk("rnd hold addr", bus.mem_addr_o, m_addr);
            chk("rnd hold we", bus.mem_we_o, m_we);
          end
        end
        default: begin
          chk("rnd recover req", bus.mem_req_o, 0);
          m_phase = 0;
        end
      endcase
      chk("rnd ins_valid", bus.ins_valid_o, e_iv);
      chk("rnd data_valid", bus.data_valid_o, e_dv);
      chk("rnd ins_rdata", bus.ins_rdata_o, m_ird);
      chk("rnd data_rdata", bus.data_rdata_o, m_drd);
      chk("rnd stall", bus.stall_o, (p_ins && !e_iv) || (p_dreq && !e_dv));
      // requesters: hold until served, then drop or retarget
      if (e_iv) bus.ins_req_i = 1'b0;
      if (!bus.ins_req_i && $urandom_range(0, 2) == 0) begin
        bus.ins_req_i  = 1'b1;
        bus.ins_addr_i = AW'($urandom);
      end
      if (e_dv) begin
        bus.data_read_i  = 1'b0;
        bus.data_write_i = 1'b0;
      end
      if (!(bus.data_read_i || bus.data_write_i) && $urandom_range(0, 1) == 0) begin
        r = $urandom_range(0, 9);
        bus.data_read_i  = (r < 5) || (r == 9);
        bus.data_write_i = (r >= 5);
        bus.data_addr_i  = AW'($urandom);
        bus.data_wdata_i = $urandom;
      end
    end
    spur_en = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
